// File: rtl/fp_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_seq_pkg
// Brief    : Shared opcodes, FSM encoding and FIFO entry layout for the
//            floating-point command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fp_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  localparam int OP_W    = 3;
  localparam int DATA_W  = 32;
  localparam int FLAGS_W = 5;
  // op + mode + two operands = 68 bits
  localparam int ENTRY_W = OP_W + 1 + 2 * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic              mode;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } cmd_entry_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

  // Half precision lives in the low 16 bits; the upper half is zeroed.
  function automatic logic [DATA_W-1:0] mode_mask(input logic mode, input logic [DATA_W-1:0] v);
    return mode ? v : {16'h0000, v[15:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fp_cmd_fifo
// Brief    : Synchronous single-clock FIFO with full/empty/count status.
//            DEPTH must be a power of two so pointers wrap naturally.
// Revision : 1.0 - initial release
// ============================================================================
module fp_cmd_fifo
  import fp_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ENTRY_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy update; simultaneous push and pop keep the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/fp_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fp_cmd_sequencer
// Brief    : Queues FP commands, issues them one at a time to an external
//            FP ALU, waits with timeout, and returns a held response.
// Revision : 1.0 - initial release
// ============================================================================
module fp_cmd_sequencer
  import fp_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic        cmd_mode,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        alu_start,
  output logic [2:0]  alu_op_code,
  output logic        alu_mode_fp,
  output logic [31:0] alu_op_a,
  output logic [31:0] alu_op_b,
  input  logic [31:0] alu_result,
  input  logic [4:0]  alu_flags,
  input  logic        alu_valid,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [4:0]  rsp_flags,
  output logic        rsp_timeout,
  output logic        rsp_illegal,
  output logic        busy
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [ENTRY_W-1:0]          fifo_wr_data;
  logic [ENTRY_W-1:0]          fifo_rd_data;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(DEPTH+1)-1:0]  fifo_count;
  logic                        fifo_pop;
  cmd_entry_t                  head;

  seq_state_t   state_q, state_d;
  logic [2:0]   op_q, op_d;
  logic         mode_q, mode_d;
  logic [31:0]  a_q, a_d;
  logic [31:0]  b_q, b_d;
  logic         alu_start_q, alu_start_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]  rsp_result_q, rsp_result_d;
  logic [4:0]   rsp_flags_q, rsp_flags_d;
  logic         rsp_timeout_q, rsp_timeout_d;
  logic         rsp_illegal_q, rsp_illegal_d;

  assign fifo_wr_data = {cmd_op, cmd_mode, cmd_a, cmd_b};
  assign head         = cmd_entry_t'(fifo_rd_data);

  fp_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cmd_valid),
    .wr_data (fifo_wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign cmd_ready   = !fifo_full;
  assign alu_op_code = op_q;
  assign alu_mode_fp = mode_q;
  assign alu_op_a    = a_q;
  assign alu_op_b    = b_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_flags   = rsp_flags_q;
  // Status strobes are forced low while reset is held.
  assign alu_start   = alu_start_q & ~rst;
  assign rsp_valid   = (state_q == ST_RESP) & ~rst;
  assign rsp_timeout = rsp_timeout_q & ~rst;
  assign rsp_illegal = rsp_illegal_q & ~rst;
  assign busy        = ((state_q != ST_IDLE) || (fifo_count != '0)) & ~rst;

  // Next-state and datapath: pop/issue, wait with timeout, hold response.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    mode_d        = mode_q;
    a_d           = a_q;
    b_d           = b_q;
    alu_start_d   = 1'b0;
    cnt_d         = cnt_q;
    rsp_result_d  = rsp_result_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_illegal_d = rsp_illegal_q;
    fifo_pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = head.op;
          mode_d   = head.mode;
          a_d      = mode_mask(head.mode, head.a);
          b_d      = mode_mask(head.mode, head.b);
          if (is_legal_op(head.op)) begin
            // Registered start pulse lines up with the ISSUE cycle.
            state_d     = ST_ISSUE;
            alu_start_d = 1'b1;
          end else begin
            state_d       = ST_RESP;
            rsp_result_d  = '0;
            rsp_flags_d   = '0;
            rsp_timeout_d = 1'b0;
            rsp_illegal_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        // cnt_d is the number of cycles elapsed since ISSUE after this one.
        cnt_d = cnt_q + 1'b1;
        if (alu_valid) begin
          state_d       = ST_RESP;
          rsp_result_d  = mode_mask(mode_q, alu_result);
          rsp_flags_d   = alu_flags;
          rsp_timeout_d = 1'b0;
          rsp_illegal_d = 1'b0;
        end else if (cnt_d == CNT_LAST) begin
          state_d       = ST_RESP;
          rsp_result_d  = '0;
          rsp_flags_d   = '0;
          rsp_timeout_d = 1'b1;
          rsp_illegal_d = 1'b0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      mode_q        <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      alu_start_q   <= 1'b0;
      cnt_q         <= '0;
      rsp_result_q  <= '0;
      rsp_flags_q   <= '0;
      rsp_timeout_q <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      mode_q        <= mode_d;
      a_q           <= a_d;
      b_q           <= b_d;
      alu_start_q   <= alu_start_d;
      cnt_q         <= cnt_d;
      rsp_result_q  <= rsp_result_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_cmd_sequencer
// Brief    : Self-checking bench: directed table, multi-cycle sequences and
//            random traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_op;
  logic        cmd_mode;
  logic [31:0] cmd_a, cmd_b;
  logic        alu_start;
  logic [2:0]  alu_op_code;
  logic        alu_mode_fp;
  logic [31:0] alu_op_a, alu_op_b, alu_result;
  logic [4:0]  alu_flags;
  logic        alu_valid;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_flags;
  logic        rsp_timeout, rsp_illegal, busy;

  always #5 clk = ~clk;

  fp_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_mode(cmd_mode),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_start(alu_start), .alu_op_code(alu_op_code), .alu_mode_fp(alu_mode_fp),
    .alu_op_a(alu_op_a), .alu_op_b(alu_op_b),
    .alu_result(alu_result), .alu_flags(alu_flags), .alu_valid(alu_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout), .rsp_illegal(rsp_illegal),
    .busy(busy)
  );

  // Reference model: accepted commands awaiting their response, in order.
  typedef struct {
    logic [2:0]  op;
    logic        mode;
    logic [31:0] a, b;
    logic        started;
    logic [31:0] res;
    logic [4:0]  flags;
    int          lat;   // 0 = ALU never answers
  } mcmd_t;
  mcmd_t mq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ALU behavioural model state
  int          alu_cd = 0;
  logic [31:0] alu_pend_res;
  logic [4:0]  alu_pend_flags;
  logic        outstanding = 1'b0;
  logic        noise_en = 1'b0;
  logic        tbl_mode = 1'b1;
  int          alu_tbl_lat = 1;
  logic [31:0] alu_tbl_res = '0;
  logic [4:0]  alu_tbl_flags = '0;
  int          start_cnt = 0;
  int          start_cyc = 0;
  logic [31:0] last_op_a = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] half_or_full(input logic mode, input logic [31:0] v);
    return mode ? v : (v & 32'h0000FFFF);
  endfunction

  task automatic check_rsp();
    mcmd_t e;
    logic [31:0] er;
    logic [4:0]  ef;
    logic        et, ei;
    if (mq.size() == 0) begin
      fail_now("rsp_unexpected");
      return;
    end
    e  = mq.pop_front();
    er = '0; ef = '0; et = 1'b0; ei = 1'b0;
    if (e.op > 3'd3) ei = 1'b1;
    else if (!e.started) fail_now("rsp_before_start");
    else if (e.lat == 0 || e.lat >= TO) et = 1'b1;
    else begin
      er = half_or_full(e.mode, e.res);
      ef = e.flags;
    end
    chk("m_rsp_result", rsp_result, er);
    chk("m_rsp_flags", 32'(rsp_flags), 32'(ef));
    chk("m_rsp_timeout", 32'(rsp_timeout), 32'(et));
    chk("m_rsp_illegal", 32'(rsp_illegal), 32'(ei));
    outstanding = 1'b0;
  endtask

  // One clock: record handshakes before the edge, then model the ALU.
  task automatic cycle();
    mcmd_t e;
    int    lat;
    if (!rst) begin
      if (cmd_valid && cmd_ready) begin
        e.op = cmd_op; e.mode = cmd_mode; e.a = cmd_a; e.b = cmd_b;
        e.started = 1'b0; e.res = '0; e.flags = '0; e.lat = 0;
        mq.push_back(e);
      end
      if (rsp_valid && rsp_ready) check_rsp();
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) return;
    alu_valid = 1'b0;
    if (alu_cd > 0) begin
      alu_cd--;
      if (alu_cd == 0) begin
        alu_valid   = 1'b1;
        alu_result  = alu_pend_res;
        alu_flags   = alu_pend_flags;
        outstanding = 1'b0;
      end
    end else if (noise_en && !outstanding && $urandom_range(0, 3) == 0) begin
      alu_valid  = 1'b1;
      alu_result = $urandom;
      alu_flags  = 5'($urandom);
    end
    if (alu_start) begin
      start_cnt++;
      start_cyc = cyc;
      last_op_a = alu_op_a;
      if (mq.size() == 0) fail_now("start_without_cmd");
      else begin
        e = mq[0];
        if (e.started) fail_now("double_start");
        chk("alu_op_code", 32'(alu_op_code), 32'(e.op));
        chk("alu_mode_fp", 32'(alu_mode_fp), 32'(e.mode));
        chk("alu_op_a", alu_op_a, half_or_full(e.mode, e.a));
        chk("alu_op_b", alu_op_b, half_or_full(e.mode, e.b));
        if (tbl_mode) begin
          lat = alu_tbl_lat; e.res = alu_tbl_res; e.flags = alu_tbl_flags;
        end else begin
          case ($urandom_range(0, 6))
            0: lat = 1;
            1: lat = 2;
            2: lat = 3;
            3: lat = 5;
            4: lat = TO - 1;
            5: lat = TO;
            default: lat = 0;
          endcase
          e.res = $urandom; e.flags = 5'($urandom);
        end
        e.started = 1'b1;
        e.lat     = lat;
        mq[0]     = e;
        outstanding    = 1'b1;
        alu_pend_res   = e.res;
        alu_pend_flags = e.flags;
        alu_cd         = lat;
      end
    end
    chk("busy", 32'(busy), 32'(mq.size() != 0));
  endtask

  typedef struct {
    logic [2:0]  op;
    logic        mode;
    logic [31:0] a, b;
    int          lat;
    logic [31:0] res;
    logic [4:0]  flags;
    logic [31:0] exp_res;
    logic [4:0]  exp_flags;
    logic        exp_to, exp_ill;
    logic [31:0] exp_op_a;
    int          exp_lat;    // cycles from push to first rsp_valid
    int          exp_starts;
  } vec_t;

  localparam int NV = 9;
  vec_t vec [NV];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t        v;
    int          push_cyc, sb, acc, hold_ok;
    logic        got;
    logic [31:0] h_res;
    logic [6:0]  h_misc;

    vec[0] = '{3'b000, 1'b1, 32'h3F800000, 32'h40000000, 1, 32'h40400000, 5'h00,
               32'h40400000, 5'h00, 1'b0, 1'b0, 32'h3F800000, 4, 1};
    vec[1] = '{3'b010, 1'b0, 32'hDEAD3C00, 32'h00004000, 2, 32'hFFFF4000, 5'h01,
               32'h00004000, 5'h01, 1'b0, 1'b0, 32'h00003C00, 5, 1};
    vec[2] = '{3'b001, 1'b1, 32'h12345678, 32'h9ABCDEF0, 3, 32'hCAFEBABE, 5'h1F,
               32'hCAFEBABE, 5'h1F, 1'b0, 1'b0, 32'h12345678, 6, 1};
    vec[3] = '{3'b011, 1'b0, 32'h0000FFFF, 32'hFFFF0001, TO-1, 32'h8765ABCD, 5'h10,
               32'h0000ABCD, 5'h10, 1'b0, 1'b0, 32'h0000FFFF, TO+2, 1};
    vec[4] = '{3'b000, 1'b1, 32'h00000001, 32'h00000002, TO, 32'h11111111, 5'h03,
               32'h00000000, 5'h00, 1'b1, 1'b0, 32'h00000001, TO+2, 1};
    vec[5] = '{3'b101, 1'b1, 32'hAAAA5555, 32'h5555AAAA, 1, 32'h22222222, 5'h04,
               32'h00000000, 5'h00, 1'b0, 1'b1, 32'h00000000, 2, 0};
    vec[6] = '{3'b111, 1'b0, 32'h01234567, 32'h89ABCDEF, 1, 32'h33333333, 5'h05,
               32'h00000000, 5'h00, 1'b0, 1'b1, 32'h00000000, 2, 0};
    vec[7] = '{3'b010, 1'b1, 32'h40A00000, 32'h40C00000, 0, 32'h44444444, 5'h06,
               32'h00000000, 5'h00, 1'b1, 1'b0, 32'h40A00000, TO+2, 1};
    vec[8] = '{3'b000, 1'b1, 32'h00C0FFEE, 32'h00000001, 1, 32'h00C0FFEF, 5'h08,
               32'h00C0FFEF, 5'h08, 1'b0, 1'b0, 32'h00C0FFEE, 4, 1};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_mode = 1'b0; cmd_a = '0; cmd_b = '0;
    alu_result = '0; alu_flags = '0; alu_valid = 1'b0; rsp_ready = 1'b0;
    repeat (3) cycle();
    rst = 1'b0;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu_start", 32'(alu_start), 32'd0);
    chk("rst_alu_op_a", alu_op_a, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);

    // ---------------- directed table ----------------
    for (int i = 0; i < NV; i++) begin
      v = vec[i];
      tbl_mode = 1'b1; alu_tbl_lat = v.lat; alu_tbl_res = v.res; alu_tbl_flags = v.flags;
      sb = start_cnt;
      cmd_valid = 1'b1; cmd_op = v.op; cmd_mode = v.mode; cmd_a = v.a; cmd_b = v.b;
      push_cyc = cyc;
      cycle();
      cmd_valid = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
        cycle();
        if (rsp_valid) got = 1'b1;
      end
      if (!got) fail_now("t_no_response");
      else begin
        chk("t_latency", 32'(cyc - push_cyc), 32'(v.exp_lat));
        chk("t_rsp_result", rsp_result, v.exp_res);
        chk("t_rsp_flags", 32'(rsp_flags), 32'(v.exp_flags));
        chk("t_rsp_timeout", 32'(rsp_timeout), 32'(v.exp_to));
        chk("t_rsp_illegal", 32'(rsp_illegal), 32'(v.exp_ill));
        chk("t_starts", 32'(start_cnt - sb), 32'(v.exp_starts));
        if (v.exp_starts == 1) begin
          chk("t_alu_op_a", last_op_a, v.exp_op_a);
          chk("t_rsp_after_issue", 32'(cyc - start_cyc), 32'(v.exp_lat - 2));
        end
      end
      rsp_ready = 1'b1;
      cycle();
      rsp_ready = 1'b0;
      cycle();
    end

    // ---------------- FIFO full with stalled ALU ----------------
    tbl_mode = 1'b1; alu_tbl_lat = 0; alu_tbl_res = 32'h0BADF00D; alu_tbl_flags = 5'h02;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_op = 3'(i % 4); cmd_mode = 1'b1;
      cmd_a = 32'h1000 + 32'(i); cmd_b = 32'h2000 + 32'(i);
      if (cmd_ready) acc++;
      cycle();
    end
    cmd_valid = 1'b0;
    chk("full_accepted", 32'(acc), 32'd5);
    hold_ok = 0;
    got = 1'b0;
    for (int k = 0; k < TO + 10 && !got; k++) begin
      if (cmd_ready) hold_ok++;
      cycle();
      if (rsp_valid) got = 1'b1;
    end
    if (!got) fail_now("full_no_response");
    chk("full_ready_high_early", 32'(hold_ok), 32'd0);
    chk("full_first_timeout", 32'(rsp_timeout), 32'd1);
    chk("full_ready_in_resp", 32'(cmd_ready), 32'd0);
    alu_tbl_lat = 1;
    rsp_ready = 1'b1;
    cycle();
    cycle();
    chk("full_ready_after_rsp", 32'(cmd_ready), 32'd1);
    for (int k = 0; k < 200 && mq.size() != 0; k++) cycle();
    if (mq.size() != 0) fail_now("full_drain");
    rsp_ready = 1'b0;

    // ---------------- response backpressure ----------------
    alu_tbl_lat = 2; alu_tbl_res = 32'h55AA55AA; alu_tbl_flags = 5'h0A;
    cmd_valid = 1'b1; cmd_op = 3'b001; cmd_mode = 1'b1; cmd_a = 32'h7; cmd_b = 32'h9;
    cycle();
    cmd_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      cycle();
      if (rsp_valid) got = 1'b1;
    end
    if (!got) fail_now("bp_no_response");
    h_res  = rsp_result;
    h_misc = {rsp_flags, rsp_timeout, rsp_illegal};
    chk("bp_result", h_res, 32'h55AA55AA);
    for (int k = 0; k < 10; k++) begin
      cycle();
      chk("bp_valid_held", 32'(rsp_valid), 32'd1);
      chk("bp_result_held", rsp_result, h_res);
      chk("bp_misc_held", 32'({rsp_flags, rsp_timeout, rsp_illegal}), 32'(h_misc));
    end
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    cycle();

    // ---------------- random traffic vs reference model ----------------
    tbl_mode = 1'b0;
    noise_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_op    = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      cmd_mode  = 1'($urandom_range(0, 1));
      cmd_a     = $urandom;
      cmd_b     = $urandom;
      rsp_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3000 && mq.size() != 0; k++) cycle();
    if (mq.size() != 0) fail_now("random_drain");
    noise_en = 1'b0;
    rsp_ready = 1'b0;
    cycle();

    // ---------------- reset while waiting on the ALU ----------------
    tbl_mode = 1'b1; alu_tbl_lat = 0;
    sb = start_cnt;
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_mode = 1'b1; cmd_a = 32'h1; cmd_b = 32'h2;
    cycle();
    cmd_a = 32'h3;
    cycle();
    cmd_valid = 1'b0;
    for (int k = 0; k < 10 && start_cnt == sb; k++) cycle();
    chk("rw_started", 32'(start_cnt - sb), 32'd1);
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    chk("rw_busy_in_rst", 32'(busy), 32'd0);
    chk("rw_valid_in_rst", 32'(rsp_valid), 32'd0);
    cycle();
    rst = 1'b0;
    mq.delete();
    outstanding = 1'b0;
    alu_cd = 0;
    alu_valid = 1'b0;
    #1;
    chk("rw_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_cmd_ready", 32'(cmd_ready), 32'd1);
    sb = start_cnt;
    rsp_ready = 1'b1;
    repeat (20) cycle();
    chk("rw_no_restart", 32'(start_cnt - sb), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fp_cmd_sequencer.md
FP_CMD_SEQUENCER -- requirements
Module: fp_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO depth, power of two, 2..16.
REQ-002 Parameter TIMEOUT, default 64: maximum WAIT cycles before abort, 2..1024.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  FIFO can accept a command.
REQ-007 cmd_op  input  3  000 ADD, 001 SUB, 010 MUL, 011 DIV; others illegal.
REQ-008 cmd_mode  input  1  0=half (16-bit), 1=single (32-bit).
REQ-009 cmd_a, cmd_b  input  32 each  operands; half uses [15:0].
REQ-010 alu_start  output  1  one-cycle start pulse to the FP ALU.
REQ-011 alu_op_code  output  3 and alu_mode_fp  output  1  registered op and mode to the ALU.
REQ-012 alu_op_a, alu_op_b  output  32 each  registered operands to the ALU.
REQ-013 alu_result  input  32, alu_flags  input  5, alu_valid  input  1  ALU outputs.
REQ-014 rsp_valid  output  1 / rsp_ready  input  1  response handshake.
REQ-015 rsp_result  output  32, rsp_flags  output  5, rsp_timeout  output  1, rsp_illegal  output  1.
REQ-016 busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-017 Command push occurs when cmd_valid and cmd_ready are both high; cmd_ready = !full.
REQ-018 Push and pop in the same cycle leave the count unchanged; pointers wrap modulo DEPTH.
REQ-019 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE with FIFO non-empty: pop head and load op, mode, and operand registers; legal op goes to ISSUE; illegal op goes to RESP with rsp_illegal=1, result 0, flags 0.
REQ-021 Half mode: alu_op_a and alu_op_b upper 16 bits are forced to 0.
REQ-022 ISSUE: alu_start=1 for exactly that cycle; go to WAIT; clear the timeout counter.
REQ-023 WAIT: alu_valid=1 captures alu_result and alu_flags and goes to RESP; alu_valid outside WAIT is ignored.
REQ-024 WAIT: when the counter reaches TIMEOUT-1 without alu_valid, go to RESP with rsp_timeout=1, result 0, flags 0.
REQ-025 alu_valid in the same cycle the counter reaches TIMEOUT-1: capture the result with timeout=0 (valid wins).
REQ-026 Half-mode captured result: bits [31:16] are forced to 0.
REQ-027 RESP: rsp_valid=1 and all rsp_* fields held stable until rsp_ready=1; then go to IDLE.
REQ-028 Minimum latency: push at cycle T, ISSUE at T+2, earliest rsp_valid at T+4 for an ALU valid at T+3.
REQ-029 Only one command in flight; FIFO accepts commands during ISSUE, WAIT, and RESP.

Reset
REQ-030 Reset values: rst clears FIFO pointers and count and sets the FSM to IDLE.
REQ-031 Outputs during reset: alu_start=0, rsp_valid=0, rsp_timeout=0, rsp_illegal=0, busy=0.
REQ-032 Output registers reset to 0; cmd_ready=1 in the cycle after reset.
REQ-033 Reset mid-operation discards the in-flight command and queued commands; no response is produced.

Structure
REQ-034 Package fp_seq_pkg contents: opcode constants (ADD, SUB, MUL, DIV), FSM state encoding, FIFO entry width 68 (op 3 + mode 1 + a 32 + b 32).
REQ-035 Sub-module fp_cmd_fifo: synchronous FIFO parameterised by DEPTH and width, with full, empty, and count outputs.
REQ-036 Register all ALU-side outputs; no combinational path from cmd_* to alu_*.

Verification
REQ-037 Single ADD: op 000, mode 1, a=0x3F800000, b=0x40000000, ALU model returns 0x40400000 -> exactly one alu_start pulse; rsp_result=0x40400000, timeout=0, illegal=0.
REQ-038 Half MUL: op 010, mode 0, a=0xDEAD3C00, b=0x00004000 -> alu_op_a=0x00003C00; ALU returns 0xFFFF4000 -> rsp_result=0x00004000.
REQ-039 FIFO full: ALU stalled, 6 back-to-back pushes with DEPTH=4 -> 5 accepted (1 popped plus 4 queued); cmd_ready low until the first response completes; responses in push order.
REQ-040 Timeout: alu_valid held 0 -> rsp_valid with rsp_timeout=1 exactly TIMEOUT cycles after ISSUE; the next command issues normally.
REQ-041 Illegal op 101 -> no alu_start; rsp_illegal=1, rsp_result=0.
REQ-042 Backpressure and reset: rsp_ready low for 10 cycles -> fields stable; rst asserted in WAIT -> next cycle rsp_valid=0, busy=0, cmd_ready=1.
